// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD power-on/host-write sequencer: states, delay classes,
// HD44780 opcodes and the init ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DELAY,
        S_IDLE
    } state_t;

    typedef enum logic [1:0] {
        DC_SHORT,
        DC_GAP,
        DC_LONG,
        DC_NONE
    } dly_cls_t;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_FUNC_SET = 8'h38;
    localparam logic [2:0] INIT_LAST   = 3'd7;

    // All init entries are commands (RS=0).
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: init_byte = OP_FUNC_SET;
            3'd4:                   init_byte = 8'h08;
            3'd5:                   init_byte = OP_CLEAR;
            3'd6:                   init_byte = 8'h06;
            default:                init_byte = 8'h0C;
        endcase
    endfunction

    function automatic dly_cls_t init_cls(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: init_cls = DC_GAP;
            3'd5:       init_cls = DC_LONG;
            default:    init_cls = DC_SHORT;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic dly_cls_t host_cls(input logic rs, input logic [7:0] data);
        host_cls = (!rs && (data == OP_CLEAR || data[7:1] == OP_HOME[7:1])) ? DC_LONG : DC_SHORT;
    endfunction

endpackage

// File: rtl/lcd_sequencer_timer.sv
// lcd_delay_timer: loadable 20-bit down-counter shared by every timed state.
// done is valid in the load cycle too, so a state lasts exactly len+1 cycles.
module lcd_delay_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] len,
    output logic        done
);
    logic [19:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (len == '0) ? '0 : len - 20'd1;
        end else if (cnt != '0) begin
            cnt <= cnt - 20'd1;
        end
    end

    assign done = load ? (len == '0) : (cnt == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 init + host-write sequencer in front of Lcd_Controller (PWRUP wait, ISSUE strobe,
// WAIT_ACK/WAIT_DONE handshake, DELAY execution time, IDLE host accept). LCD_BUSY_POLL_EN: busy-flag polling after host writes.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int GAP_CYC     = 205000,
    parameter int SHORT_CYC   = 2500,
    parameter int LONG_CYC    = 82000,
    parameter int ACK_TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       err,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    output logic       lcd_ncs,
    output logic       lcd_nwr,
    output logic       lcd_nrd,
    output logic       lcd_rs,
    input  logic       ctl_rdy
);
    state_t      state, prev_state;
    dly_cls_t    cls;
    logic [2:0]  idx;
    logic [19:0] tmr_len;
    logic        tmr_done;
    logic        enter;

`ifdef LCD_BUSY_POLL_EN
    logic       rd_op;
    logic [7:0] poll_cnt;
    logic       unused_db;
    assign unused_db = ^db_in[6:0];
`else
    logic       unused_db;
    assign unused_db = ^db_in;
`endif

    function automatic logic [19:0] cls_len(input dly_cls_t c);
        case (c)
            DC_GAP:   cls_len = 20'(GAP_CYC - 1);
            DC_LONG:  cls_len = 20'(LONG_CYC - 1);
            DC_SHORT: cls_len = 20'(SHORT_CYC - 1);
            default:  cls_len = 20'd0;
        endcase
    endfunction

    // The timer restarts on every state change; prev_state resets to a different state so PWRUP counts from reset.
    assign enter     = (state != prev_state);
    assign req_ready = (state == S_IDLE);

    always_comb begin
        tmr_len = '0;
        case (state)
            S_PWRUP:                 tmr_len = 20'(POWERUP_CYC - 1);
            S_WAIT_ACK, S_WAIT_DONE: tmr_len = 20'(ACK_TIMEOUT - 1);
            S_DELAY:                 tmr_len = cls_len(cls);
            default:                 tmr_len = '0;
        endcase
    end

    lcd_delay_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (enter),
        .len  (tmr_len),
        .done (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_PWRUP;
            prev_state <= S_IDLE;
            cls        <= DC_SHORT;
            idx        <= '0;
            lcd_ncs    <= 1'b1;
            lcd_nwr    <= 1'b1;
            lcd_nrd    <= 1'b1;
            lcd_rs     <= 1'b0;
            db_out     <= '0;
            db_oe      <= 1'b0;
            init_done  <= 1'b0;
            err        <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            rd_op      <= 1'b0;
            poll_cnt   <= '0;
`endif
        end else begin
            prev_state <= state;
            case (state)
                S_PWRUP: begin
                    if (tmr_done) begin
                        idx     <= '0;
                        db_out  <= init_byte(3'd0);
                        cls     <= init_cls(3'd0);
                        lcd_rs  <= 1'b0;
                        db_oe   <= 1'b1;
                        lcd_ncs <= 1'b0;
                        lcd_nwr <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lcd_ncs <= 1'b1;
                    lcd_nwr <= 1'b1;
                    lcd_nrd <= 1'b1;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!ctl_rdy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmr_done) begin
                        err   <= 1'b1;
                        db_oe <= 1'b0;
                        state <= S_DELAY;
                    end
                end
                S_WAIT_DONE: begin
                    if (ctl_rdy) begin
`ifdef LCD_BUSY_POLL_EN
                        if (init_done && (!rd_op || (db_in[7] && poll_cnt != 8'd254))) begin
                            poll_cnt <= rd_op ? poll_cnt + 8'd1 : 8'd0;
                            rd_op    <= 1'b1;
                            lcd_rs   <= 1'b0;
                            db_oe    <= 1'b0;
                            lcd_ncs  <= 1'b0;
                            lcd_nrd  <= 1'b0;
                            state    <= S_ISSUE;
                        end else begin
                            // A still-busy flag here means the poll budget ran out.
                            if (rd_op) begin
                                cls <= DC_NONE;
                                err <= err | db_in[7];
                            end
                            db_oe <= 1'b0;
                            state <= S_DELAY;
                        end
`else
                        db_oe <= 1'b0;
                        state <= S_DELAY;
`endif
                    end else if (tmr_done) begin
                        err   <= 1'b1;
                        db_oe <= 1'b0;
                        state <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (tmr_done) begin
`ifdef LCD_BUSY_POLL_EN
                        rd_op <= 1'b0;
`endif
                        if (init_done) begin
                            state <= S_IDLE;
                        end else if (idx == INIT_LAST) begin
                            init_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            idx     <= idx + 3'd1;
                            db_out  <= init_byte(idx + 3'd1);
                            cls     <= init_cls(idx + 3'd1);
                            lcd_rs  <= 1'b0;
                            db_oe   <= 1'b1;
                            lcd_ncs <= 1'b0;
                            lcd_nwr <= 1'b0;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        db_out  <= req_data;
                        lcd_rs  <= req_rs;
                        cls     <= host_cls(req_rs, req_data);
                        db_oe   <= 1'b1;
                        lcd_ncs <= 1'b0;
                        lcd_nwr <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with shortened delays and a cycle-accurate Lcd_Controller model.
module tb_lcd_sequencer;
    localparam int P_PWR   = 40;
    localparam int P_GAP   = 20;
    localparam int P_SHORT = 10;
    localparam int P_LONG  = 30;
    localparam int P_ACK   = 63;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valid = 1'b0, req_rs = 1'b0;
    logic [7:0] req_data = 8'h00, db_in = 8'h00;
    logic       ctl_rdy = 1'b1;
    logic       req_ready, init_done, err, db_oe, lcd_ncs, lcd_nwr, lcd_nrd, lcd_rs;
    logic [7:0] db_out;

    int checks = 0, errors = 0;

    lcd_sequencer #(
        .POWERUP_CYC (P_PWR),
        .GAP_CYC     (P_GAP),
        .SHORT_CYC   (P_SHORT),
        .LONG_CYC    (P_LONG),
        .ACK_TIMEOUT (P_ACK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .err       (err),
        .db_out    (db_out),
        .db_oe     (db_oe),
        .db_in     (db_in),
        .lcd_ncs   (lcd_ncs),
        .lcd_nwr   (lcd_nwr),
        .lcd_nrd   (lcd_nrd),
        .lcd_rs    (lcd_rs),
        .ctl_rdy   (ctl_rdy)
    );

    always #5 clk = ~clk;

    // Controller model: RDY drops the cycle after a strobe is seen and stays low 30 cycles.
    logic model_ack = 1'b1;
    int   busy_reads = 0, reads_served = 0, m_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
        end else if (m_cnt == 0) begin
            if (model_ack && !lcd_ncs) begin
                m_cnt = 1;
                if (!lcd_nrd) begin
                    db_in = (reads_served < busy_reads) ? 8'h80 : 8'h00;
                    reads_served++;
                end
            end
        end else begin
            m_cnt = (m_cnt == 31) ? 0 : m_cnt + 1;
        end
        #1 ctl_rdy = !(m_cnt >= 2);
    end

    // Monitor: cycle index, write strobes, read strobes, RDY rising edges.
    int         cyc = 0, n_reads = 0, wide_err = 0;
    logic       prev_ncs = 1'b1, prev_rdy = 1'b1;
    logic [7:0] s_data[$];
    logic       s_rs[$];
    int         s_cyc[$];
    int         rise_cyc[$];
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; n_reads = 0; wide_err = 0; prev_ncs = 1'b1; prev_rdy = 1'b1;
            s_data.delete(); s_rs.delete(); s_cyc.delete(); rise_cyc.delete();
        end else begin
            if (!lcd_ncs && !lcd_nwr) begin
                s_data.push_back(db_out); s_rs.push_back(lcd_rs); s_cyc.push_back(cyc);
            end
            if (!lcd_ncs && !lcd_nrd) n_reads++;
            if (!lcd_ncs && !prev_ncs) wide_err++;
            if (ctl_rdy && !prev_rdy) rise_cyc.push_back(cyc);
            prev_ncs = lcd_ncs; prev_rdy = ctl_rdy; cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    function automatic bit sig(input int which, input int target);
        case (which)
            0:       return req_ready;
            1:       return init_done;
            2:       return err;
            3:       return !lcd_ncs;
            4:       return s_cyc.size() >= target;
            default: return rise_cyc.size() >= target;
        endcase
    endfunction

    task automatic wait_until(input string name, input int which, input int target, input int limit, output int at);
        at = -1;
        for (int k = 0; k <= limit; k++) begin
            if (sig(which, target)) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL %s: condition still false after %0d cycles, expected true", name, limit);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         dly;
    } vec_t;

    initial begin
        vec_t       vecs[7];
        logic [7:0] init_exp[8];
        int         init_dly[8];
        int         t, t2, base, rbase, n;

        init_exp = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        init_dly = '{P_GAP, P_GAP, P_SHORT, P_SHORT, P_SHORT, P_LONG, P_SHORT, P_SHORT};
        vecs[0] = '{1'b1, 8'h41, P_SHORT};
        vecs[1] = '{1'b0, 8'h01, P_LONG};
        vecs[2] = '{1'b0, 8'h02, P_LONG};
        vecs[3] = '{1'b0, 8'h03, P_LONG};
        vecs[4] = '{1'b0, 8'h04, P_SHORT};
        vecs[5] = '{1'b1, 8'h01, P_SHORT};
        vecs[6] = '{1'b0, 8'h38, P_SHORT};

        // Reset values
        #12;
        check("reset_outputs", {lcd_ncs, lcd_nwr, lcd_nrd, lcd_rs, db_oe, req_ready, init_done, err, db_out}, 16'hE000);
        @(negedge clk); rst = 1'b0;

        // Power-on init sequence
        wait_until("init_done", 1, 0, 3000, t);
        check("init_strobe_count", s_cyc.size(), 8);
        n = (s_cyc.size() < 8) ? s_cyc.size() : 8;
        for (int i = 0; i < n; i++) begin
            check($sformatf("init_byte_%0d", i), s_data[i], init_exp[i]);
            check($sformatf("init_rs_%0d", i), s_rs[i], 0);
        end
        if (n > 0) check("first_strobe_cycle", s_cyc[0], P_PWR);
        for (int i = 0; i < n - 1 && i < rise_cyc.size(); i++)
            check($sformatf("init_delay_%0d", i), s_cyc[i+1] - rise_cyc[i], init_dly[i] + 1);
        if (rise_cyc.size() >= 8) check("init_done_cycle", t - rise_cyc[7], P_SHORT + 1);
        check("init_err", err, 0);
        check("strobe_width", wide_err, 0);

`ifndef LCD_BUSY_POLL_EN
        // Host writes, fixed execution delays
        for (int i = 0; i < 7; i++) begin
            base = s_cyc.size(); rbase = rise_cyc.size();
            req_rs = vecs[i].rs; req_data = vecs[i].data; req_valid = 1'b1;
            wait_until($sformatf("host_ready_%0d", i), 0, 0, 500, t);
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("ready_pulse_%0d", i), req_ready, 0);
            wait_until($sformatf("host_strobe_%0d", i), 4, base + 1, 100, t2);
            if (s_cyc.size() > base) begin
                check($sformatf("host_data_%0d", i), s_data[base], vecs[i].data);
                check($sformatf("host_rs_%0d", i), s_rs[base], vecs[i].rs);
                check($sformatf("host_strobe_cycle_%0d", i), s_cyc[base] - t, 1);
            end
            wait_until($sformatf("host_rdy_rise_%0d", i), 5, rbase + 1, 100, t2);
            wait_until($sformatf("host_next_ready_%0d", i), 0, 0, 500, t2);
            if (rise_cyc.size() > rbase)
                check($sformatf("host_delay_%0d", i), t2 - rise_cyc[rbase], vecs[i].dly + 1);
        end
        check("no_read_strobes", n_reads, 0);
`else
        // Host write followed by busy-flag polling: busy for three reads, then free
        reads_served = 0; busy_reads = 3;
        req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
        wait_until("poll_ready", 0, 0, 500, t);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("poll_ready_pulse", req_ready, 0);
        wait_until("poll_done_ready", 0, 0, 2000, t2);
        check("poll_read_count", n_reads, 4);
        check("poll_err", err, 0);
        busy_reads = 0;
`endif

        // Reset while init index 4 is waiting for RDY to return
        do_reset();
        wait_until("strobe_idx4", 4, 5, 3000, t);
        repeat (10) @(negedge clk);
        check("oe_in_wait_done", db_oe, 1);
        #1 rst = 1'b1;
        #1 check("reset_mid_outputs", {lcd_ncs, lcd_nwr, lcd_nrd, db_oe, init_done}, 5'b11100);
        @(negedge clk); rst = 1'b0;
        wait_until("restart_strobe", 3, 0, 200, t);
        check("restart_strobe_cycle", t, P_PWR);
        check("restart_strobe_byte", db_out, 8'h38);
        // Reset while a strobe is low
        #1 rst = 1'b1;
        #1 check("reset_in_strobe", {lcd_ncs, lcd_nwr}, 2'b11);
        @(negedge clk); rst = 1'b0;

        // Controller never acknowledges: timeout flags err, sequencing still finishes
        model_ack = 1'b0;
        do_reset();
        wait_until("timeout_err", 2, 0, 500, t);
        check("timeout_err_cycle", t, P_PWR + 1 + P_ACK);
        wait_until("timeout_init_done", 1, 0, 3000, t);
        check("timeout_init_done", init_done, 1);
        check("timeout_strobes", s_cyc.size(), 8);
        check("timeout_err_sticky", err, 1);
        model_ack = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Sits between the EPC-side host logic and Lcd_Controller; owns that controller's nCS/nWR/nRD/RS strobe inputs and its RDY output.
- After reset it runs the HD44780 power-on init sequence autonomously.
- It then accepts single-byte command/data write requests over a valid/ready handshake. It issues each request to the controller and enforces the LCD execution time before accepting the next one.

Parameters:
- POWERUP_CYC, 750000, cycles waited after reset before the first init write (15 ms at 50 MHz).
- GAP_CYC, 205000, wait after the first and second function-set writes (4.1 ms).
- SHORT_CYC, 2500, execution wait after an ordinary command/data write (50 us).
- LONG_CYC, 82000, execution wait after a clear (0x01) or home (0x02/0x03) command (1.64 ms).
- ACK_TIMEOUT, 63, maximum cycles allowed per controller handshake phase.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  host has a byte to write
- req_rs  in  1  0 = command, 1 = display data
- req_data  in  8  byte to write
- req_ready  out  1  sequencer accepts a request this cycle
- init_done  out  1  init sequence complete; sticky until reset
- err  out  1  sticky handshake-timeout flag
- db_out  out  8  LCD data bus drive value
- db_oe  out  1  LCD data bus output enable
- db_in  in  8  LCD data bus read value (used only with the optional feature)
- lcd_ncs  out  1  to controller nCS, active low
- lcd_nwr  out  1  to controller nWR, active low
- lcd_nrd  out  1  to controller nRD, active low
- lcd_rs  out  1  to controller RS
- ctl_rdy  in  1  controller RDY

Behaviour:
- Reset (asynchronous):
  - lcd_ncs, lcd_nwr and lcd_nrd are 1.
  - lcd_rs, db_oe, req_ready, init_done and err are 0; db_out is 0x00.
  - State is S_PWRUP and the 20-bit delay counter is 0.
  - Reset mid-transaction deasserts all strobes immediately and restarts the full init sequence.
- States: S_PWRUP, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DELAY, S_IDLE.
- S_PWRUP: count to POWERUP_CYC-1, then S_ISSUE with init index 0.
- Init ROM, 8 entries, all RS=0: 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C.
  - Delay after index 0 and 1: GAP_CYC.
  - Delay after index 5: LONG_CYC.
  - Delay after all other entries: SHORT_CYC.
- S_ISSUE:
  - db_out is set to the byte, db_oe=1, lcd_rs is set to the RS bit.
  - lcd_ncs and lcd_nwr are low for exactly one cycle.
  - Next state is S_WAIT_ACK.
- S_WAIT_ACK: wait for ctl_rdy=0, then go to S_WAIT_DONE.
- S_WAIT_DONE: wait for ctl_rdy=1, then go to S_DELAY with the delay selected for that byte.
- Timeouts: exceeding ACK_TIMEOUT cycles in S_WAIT_ACK or S_WAIT_DONE sets err=1 and goes to S_DELAY anyway. Sequencing never hangs.
- Host writes use the LONG_CYC delay when the request is RS=0 with data 0x01, 0x02 or 0x03; otherwise SHORT_CYC.
- lcd_rs and db_out hold their values through S_WAIT_DONE. db_oe drops to 0 on entry to S_DELAY.
- S_DELAY completion:
  - If init is incomplete: advance the index and go to S_ISSUE.
  - After index 7: set init_done=1 and go to S_IDLE.
  - After a host write: go to S_IDLE.
- S_IDLE: req_ready=1 combinationally.
  - A transfer occurs on req_valid && req_ready.
  - The request is latched in the same cycle and S_ISSUE follows on the next edge.
  - req_ready is 0 in every other state. No queueing: the host holds the request until it is accepted.
- Delay counter: clears on every state entry and compares equal to N-1; it never wraps.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- Defined:
  - Host-write delays are replaced by busy-flag polling: read with RS=0, lcd_ncs and lcd_nrd low for one cycle, using the same ack/done handshake.
  - db_in[7] is sampled on the ctl_rdy rising edge; polling repeats while it is 1, with a maximum of 255 polls before err is set.
  - Init entries 0–2 always use fixed delays.
- Undefined: fixed delays only; db_in is ignored.

Decomposition:
- Package lcd_pkg holds:
  - state encoding constants;
  - init ROM contents and per-entry delay-class codes;
  - opcode constants 0x01, 0x02 and 0x38.
- One natural sub-module, lcd_delay_timer: a loadable 20-bit down-counter with a done pulse, shared by all delay states.

Test Plan:
- Reset release, controller model returns RDY low after 1 cycle and high after 30 cycles:
  - exactly 8 write strobes with db_out 0x38, 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C, all RS=0;
  - first strobe at cycle 750000;
  - init_done rises after the last SHORT_CYC.
- After init, req_rs=1, req_data=0x41 held valid:
  - req_ready pulses once;
  - one strobe with lcd_rs=1 and db_out=0x41;
  - next req_ready at least 2500 cycles after ctl_rdy returns high.
- Request RS=0, data 0x01: the following request is accepted no earlier than 82000 cycles after the handshake completes.
- Controller model never lowers RDY:
  - err=1 after 63 cycles;
  - sequencing continues and init_done is still reached.
- Reset asserted during S_WAIT_DONE of init index 4: strobes go high immediately, and the sequence restarts from S_PWRUP with a fresh 750000-cycle wait.
- With LCD_BUSY_POLL_EN, db_in[7]=1 for 3 reads then 0: 4 read strobes occur, then req_ready=1, and err stays 0.
